io_timer_irq: RTL

//  Memory-mapped timer and interrupt source on the cpu6502 bus, replacing the bare
//  io_port latch at 16'hbffc. Decodes the CPU's next-cycle address and write strobe, and

---
 rtl/io_timer_irq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/io_timer_irq.sv
// io_timer_irq: memory-mapped 16-bit down-counter timer and irq/nmi source on the cpu6502 bus.
// Latency: register writes land on the clk edge of write_next; reads are combinational; irq/nmi lag their cause by one clk.
// Backpressure: none; the CPU bus never stalls, and tick_en alone gates counting.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   tick_en                    count qualifier (CPU clock enable)
//   address                    current CPU address, selects data_o / cs
//   address_next, write_next   next-cycle write target and strobe
//   data_i                     CPU write data
//   cs, data_o                 window hit and read data for address
//   irq, nmi                   registered interrupt lines to the CPU
//
// Register window at BASE_ADDR (8 bytes):
//   +0 CTRL   {3'b0, sw_nmi, sw_irq, tie, cont, run}
//   +1 CNT_LO w: latch[7:0]; r: counter[7:0], snapshots counter[15:8]
//   +2 CNT_HI w: latch[15:8] and load counter; r: snapshot
//   +3 STATUS r: {7'b0, tflag}; w: bit0 clears tflag
//   +4 PRESC  prescaler reload (only with IO_TIMER_PRESCALE_EN)
// Optional feature macro: IO_TIMER_PRESCALE_EN enables the 8-bit prescaler.

module io_timer_irq #(
    parameter logic [15:0] BASE_ADDR   = 16'hbff8,
    parameter logic [15:0] RESET_LATCH = 16'hffff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_en,
    input  logic [15:0] address,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_i,
    output logic        cs,
    output logic [7:0]  data_o,
    output logic        irq,
    output logic        nmi
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        cont;
    logic        tie;
    logic        sw_irq;
    logic        sw_nmi;
    logic        tflag;
    logic        tflag_next;
    logic [15:0] latch;
    logic [15:0] counter;
    logic [15:0] cnt_next;
    logic [7:0]  hi_snap;
    logic [7:0]  presc_rd;

    logic        tick_eff;
    logic        underflow;

    // Write decode on the next-cycle address.
    logic        wr_win;
    logic        wr_ctrl;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_stat;

    assign wr_win  = write_next && (address_next[15:3] == BASE_ADDR[15:3]);
    assign wr_ctrl = wr_win && (address_next[2:0] == 3'd0);
    assign wr_lo   = wr_win && (address_next[2:0] == 3'd1);
    assign wr_hi   = wr_win && (address_next[2:0] == 3'd2);
    assign wr_stat = wr_win && (address_next[2:0] == 3'd3);

    assign cs = (address[15:3] == BASE_ADDR[15:3]);

`ifdef IO_TIMER_PRESCALE_EN
    logic       wr_presc;
    logic [7:0] presc;
    logic [7:0] pc;

    assign wr_presc = wr_win && (address_next[2:0] == 3'd4);

    // Free-running prescaler: one effective tick each time pc is found at 0,
    // giving a period of presc+1 tick_en pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= 8'h00;
            pc    <= 8'h00;
        end else if (wr_presc) begin
            presc <= data_i;
            pc    <= data_i;
        end else if (tick_en) begin
            if (pc == 8'h00) begin
                pc <= presc;
            end else begin
                pc <= pc - 8'd1;
            end
        end
    end

    assign tick_eff = tick_en && (pc == 8'h00);
    assign presc_rd = presc;
`else
    assign tick_eff = tick_en;
    assign presc_rd = 8'h00;
`endif

    assign underflow = (state == ST_RUN) && tick_eff && (counter == 16'h0000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Priority, lowest to highest: counting, CTRL write, STATUS clear, CNT_HI load.
    always_comb begin
        state_next = state;
        cnt_next   = counter;
        tflag_next = tflag;

        if ((state == ST_RUN) && tick_eff) begin
            if (counter == 16'h0000) begin
                tflag_next = 1'b1;
                if (cont) begin
                    cnt_next = latch;
                end else begin
                    cnt_next   = 16'h0000;
                    state_next = ST_STOP;
                end
            end else begin
                cnt_next = counter - 16'd1;
            end
        end

        if (wr_ctrl) begin
            state_next = data_i[0] ? ST_RUN : ST_STOP;
            // Stopping on the underflow edge leaves the counter at 0 rather than reloading.
            if (!data_i[0] && underflow) begin
                cnt_next = counter;
            end
        end

        // An underflow on the same edge as a clear keeps the flag set.
        if (wr_stat && data_i[0] && !underflow) begin
            tflag_next = 1'b0;
        end

        if (wr_hi) begin
            cnt_next   = {data_i, latch[7:0]};
            tflag_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cont    <= 1'b0;
            tie     <= 1'b0;
            sw_irq  <= 1'b0;
            sw_nmi  <= 1'b0;
            tflag   <= 1'b0;
            latch   <= RESET_LATCH;
            counter <= RESET_LATCH;
            hi_snap <= 8'h00;
            irq     <= 1'b0;
            nmi     <= 1'b0;
        end else begin
            tflag   <= tflag_next;
            counter <= cnt_next;
            if (wr_ctrl) begin
                cont   <= data_i[1];
                tie    <= data_i[2];
                sw_irq <= data_i[3];
                sw_nmi <= data_i[4];
            end
            if (wr_lo) begin
                latch[7:0] <= data_i;
            end
            if (wr_hi) begin
                latch[15:8] <= data_i;
            end
            // Reading CNT_LO freezes the high byte so a following CNT_HI read is coherent.
            if (cs && (address[2:0] == 3'd1)) begin
                hi_snap <= counter[15:8];
            end
            irq <= (tflag & tie) | sw_irq;
            nmi <= sw_nmi;
        end
    end

    always_comb begin
        data_o = 8'h00;
        if (cs) begin
            case (address[2:0])
                3'd0:    data_o = {3'b000, sw_nmi, sw_irq, tie, cont, (state == ST_RUN)};
                3'd1:    data_o = counter[7:0];
                3'd2:    data_o = hi_snap;
                3'd3:    data_o = {7'b0000000, tflag};
                3'd4:    data_o = presc_rd;
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule
